// File: rtl/counter.sv
`default_nettype none
// ============================================================================
// Module   : counter
// Purpose  : 8-bit up/down count core of the 8-bit timer. Holds TCNT, supports
//            synchronous parallel load, and raises sticky overflow/underflow
//            flags on wrap-around that are cleared by explicit clear inputs.
// Revision : 1.0 - initial release
// ============================================================================
module counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_ena,
  input  logic [7:0] start_counter,
  input  logic       up_down,
  input  logic       load,
  input  logic       enable,
  input  logic       clr_overflow,
  input  logic       clr_underflow,
  output logic       overflow,
  output logic       underflow
);

  localparam logic [7:0] C_MAX = 8'hFF;
  localparam logic [7:0] C_MIN = 8'h00;

  // TCNT keeps its historical name so external benches can probe it.
  logic [7:0] reg_TCNT;
  logic [7:0] tcnt_d;
  logic       overflow_q;
  logic       overflow_d;
  logic       underflow_q;
  logic       underflow_d;

  // A count step happens only when both the prescaler strobe and the enable are high.
  logic w_step;
  assign w_step = enable & clk_ena;

  // Next-state: load beats counting; a wrap on the same edge as a clear wins.
  always_comb begin
    tcnt_d      = reg_TCNT;
    overflow_d  = overflow_q  & ~clr_overflow;
    underflow_d = underflow_q & ~clr_underflow;
    if (load) begin
      tcnt_d = start_counter;
    end else if (w_step) begin
      if (up_down) begin
        tcnt_d = reg_TCNT + 8'd1;
        if (reg_TCNT == C_MAX) begin
          overflow_d = 1'b1;
        end
      end else begin
        tcnt_d = reg_TCNT - 8'd1;
        if (reg_TCNT == C_MIN) begin
          underflow_d = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_TCNT    <= 8'h00;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      reg_TCNT    <= tcnt_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter
// Purpose  : Self-checking bench for counter. A reference model pushes the
//            expected TCNT/flags into a scoreboard queue as each step is
//            driven; the entry is popped and compared after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter;

  logic       clk;
  logic       rst_n;
  logic       clk_ena;
  logic [7:0] start_counter;
  logic       up_down;
  logic       load;
  logic       enable;
  logic       clr_overflow;
  logic       clr_underflow;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] tcnt;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic [7:0] m_tcnt;
  logic       m_ovf;
  logic       m_unf;

  counter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clk_ena       (clk_ena),
    .start_counter (start_counter),
    .up_down       (up_down),
    .load          (load),
    .enable        (enable),
    .clr_overflow  (clr_overflow),
    .clr_underflow (clr_underflow),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one clock cycle of stimulus, predict the result, then compare after the edge.
  task automatic step(input logic ld, input logic [7:0] st, input logic ce,
                      input logic en, input logic ud, input logic co, input logic cu);
    exp_t e;
    logic wrap_o;
    logic wrap_u;
    load          = ld;
    start_counter = st;
    clk_ena       = ce;
    enable        = en;
    up_down       = ud;
    clr_overflow  = co;
    clr_underflow = cu;
    wrap_o = 1'b0;
    wrap_u = 1'b0;
    if (ld) begin
      m_tcnt = st;
    end else if (en && ce) begin
      if (ud) begin
        wrap_o = (m_tcnt == 8'd255);
        m_tcnt = (m_tcnt == 8'd255) ? 8'd0 : m_tcnt + 8'd1;
      end else begin
        wrap_u = (m_tcnt == 8'd0);
        m_tcnt = (m_tcnt == 8'd0) ? 8'd255 : m_tcnt - 8'd1;
      end
    end
    m_ovf = wrap_o ? 1'b1 : (co ? 1'b0 : m_ovf);
    m_unf = wrap_u ? 1'b1 : (cu ? 1'b0 : m_unf);
    e.tcnt = m_tcnt;
    e.ovf  = m_ovf;
    e.unf  = m_unf;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("tcnt", dut.reg_TCNT, e.tcnt);
    chk("overflow", {7'd0, overflow}, {7'd0, e.ovf});
    chk("underflow", {7'd0, underflow}, {7'd0, e.unf});
  endtask

  initial begin
    rst_n = 1'b0;
    load = 1'b0; start_counter = 8'h00; clk_ena = 1'b0; enable = 1'b0;
    up_down = 1'b0; clr_overflow = 1'b0; clr_underflow = 1'b0;
    m_tcnt = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;

    // Reset held for five clocks, released away from the edge
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("reset_tcnt", dut.reg_TCNT, 8'h00);
    chk("reset_ovf", {7'd0, overflow}, 8'h00);
    chk("reset_unf", {7'd0, underflow}, 8'h00);
    step(0, 8'h00, 0, 0, 1, 0, 0);
    step(0, 8'h00, 1, 0, 1, 0, 0);          // strobe without enable: still zero

    // Up-count from 0 with a clk/4 strobe; start_counter changes after 200 strobes
    step(1, 8'h00, 0, 1, 1, 0, 0);
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 3; k++) step(0, (i >= 200) ? 8'd50 : 8'd0, 0, 1, 1, 0, 0);
      if (i == 255) chk("ovf_before_wrap", {7'd0, overflow}, 8'h00);
      step(0, (i >= 200) ? 8'd50 : 8'd0, 1, 1, 1, 0, 0);
      if (i == 200) chk("no_load_effect", dut.reg_TCNT, 8'd201);
    end
    chk("wrap_tcnt", dut.reg_TCNT, 8'h00);
    chk("wrap_ovf", {7'd0, overflow}, 8'h01);
    chk("wrap_unf", {7'd0, underflow}, 8'h00);

    // Clear overflow
    step(0, 8'h00, 0, 1, 1, 1, 0);
    chk("clr_ovf", {7'd0, overflow}, 8'h00);

    // Down-count underflow from 3
    step(1, 8'd3, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 8'd3, 1, 1, 0, 0, 0);
    chk("down_tcnt", dut.reg_TCNT, 8'hFF);
    chk("down_unf", {7'd0, underflow}, 8'h01);
    chk("down_ovf", {7'd0, overflow}, 8'h00);

    // Disabled: strobes do not move the counter; clear still works
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 1, 0, 0);
    chk("hold_tcnt", dut.reg_TCNT, 8'hFF);
    step(0, 8'h00, 1, 0, 1, 0, 1);
    chk("hold_clr_unf", {7'd0, underflow}, 8'h00);

    // Direction change mid-run: down then up, no wrap so no flags
    step(1, 8'h10, 0, 1, 0, 0, 0);
    step(0, 8'h10, 1, 1, 0, 0, 0);
    step(0, 8'h10, 1, 1, 1, 0, 0);
    step(0, 8'h10, 1, 1, 1, 0, 0);
    chk("dir_tcnt", dut.reg_TCNT, 8'h11);

    // Clear coincident with an overflow wrap: set wins
    step(0, 8'h00, 0, 1, 1, 0, 0);
    step(1, 8'hFF, 0, 1, 1, 0, 0);
    step(0, 8'hFF, 1, 1, 1, 1, 0);
    chk("clr_vs_set_ovf", {7'd0, overflow}, 8'h01);
    // Same for underflow
    step(1, 8'h00, 0, 1, 0, 1, 0);
    step(0, 8'h00, 1, 1, 0, 0, 1);
    chk("clr_vs_set_unf", {7'd0, underflow}, 8'h01);

    // Load priority over a coincident strobe, then two up strobes wrap
    step(1, 8'hFE, 1, 1, 1, 1, 1);
    chk("load_prio_tcnt", dut.reg_TCNT, 8'hFE);
    chk("load_prio_ovf", {7'd0, overflow}, 8'h00);
    step(0, 8'h00, 1, 1, 1, 0, 0);
    step(0, 8'h00, 1, 1, 1, 0, 0);
    chk("load_wrap_tcnt", dut.reg_TCNT, 8'h00);
    chk("load_wrap_ovf", {7'd0, overflow}, 8'h01);

    // Asynchronous reset mid-operation
    step(0, 8'h00, 1, 1, 1, 0, 0);
    step(0, 8'h00, 1, 1, 0, 0, 0);
    step(0, 8'h00, 1, 1, 0, 0, 0);          // underflow set here
    #2 rst_n = 1'b0;
    #1;
    m_tcnt = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
    chk("async_rst_tcnt", dut.reg_TCNT, 8'h00);
    chk("async_rst_ovf", {7'd0, overflow}, 8'h00);
    chk("async_rst_unf", {7'd0, underflow}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 8'h00, 1, 1, 1, 0, 0);

    chk("sb_empty", 8'(sb_q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
